// File: rtl/redir_ctrl_pkg.sv
// Shared widths and FSM state encodings for the branch redirect controller.
// Width macros may be overridden on the command line before this file is read.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package redir_ctrl_pkg;
    localparam int PC_W   = `PC_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDIR  = 2'd1,
        ST_REFILL = 2'd2
    } state_e;
endpackage

// File: rtl/redir_ctrl_if.sv
// Branch-resolution and fetch-redirect signals between EX, fetch and the redirect controller.
interface redir_ctrl_if;
    import redir_ctrl_pkg::*;

    logic            bru_output_vld;
    logic            bru_flush;
    logic [PC_W-1:0] bru_redir_pc;
    logic            redir_rdy;
    logic            flush_o;
    logic            stall_o;
    logic            redir_vld_o;
    logic [PC_W-1:0] redir_pc_o;
    logic            pc_misalign_o;

    modport master (
        output bru_output_vld, bru_flush, bru_redir_pc, redir_rdy,
        input  flush_o, stall_o, redir_vld_o, redir_pc_o, pc_misalign_o
    );

    modport slave (
        input  bru_output_vld, bru_flush, bru_redir_pc, redir_rdy,
        output flush_o, stall_o, redir_vld_o, redir_pc_o, pc_misalign_o
    );
endinterface

// File: rtl/redir_ctrl_perf_cnt.sv
// Branch and taken-branch event counters; both wrap from all-ones to zero.
module redir_ctrl_perf_cnt
    import redir_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              br_inc_i,
    input  logic              taken_inc_i,
    output logic [DATA_W-1:0] br_cnt_o,
    output logic [DATA_W-1:0] taken_cnt_o
);
    logic [DATA_W-1:0] br_cnt_q, br_cnt_d;
    logic [DATA_W-1:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        br_cnt_d    = br_inc_i    ? br_cnt_q + 1'b1    : br_cnt_q;
        taken_cnt_d = taken_inc_i ? taken_cnt_q + 1'b1 : taken_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt_o    = br_cnt_q;
    assign taken_cnt_o = taken_cnt_q;
endmodule

// File: rtl/redir_ctrl.sv
// Taken-branch redirect controller: flush, redirect handshake to fetch, refill bubble.
// Optional BRU_PERF_CNT_EN adds branch/taken event counters.
//   state     | meaning
//   ST_IDLE   | watching EX for a taken, aligned branch
//   ST_REDIR  | redirect presented to fetch, waiting for redir_rdy
//   ST_REFILL | bubble cycles while fetch refills from the new PC
module redir_ctrl
    import redir_ctrl_pkg::*;
#(
    parameter int unsigned REFILL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    redir_ctrl_if.slave       bus
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [DATA_W-1:0] br_cnt_o,
    output logic [DATA_W-1:0] taken_cnt_o
`endif
);
    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    logic idle, taken, aligned, do_flush;

    assign idle     = (state_q == ST_IDLE);
    assign taken    = idle & bus.bru_output_vld & bus.bru_flush;
    assign aligned  = (bus.bru_redir_pc[1:0] == 2'b00);
    assign do_flush = taken & aligned & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pc_q       <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        misalign_d = taken & ~aligned;
        unique case (state_q)
            ST_IDLE: begin
                if (do_flush) begin
                    state_d = ST_REDIR;
                    pc_d    = bus.bru_redir_pc;
                end
            end
            ST_REDIR: begin
                if (bus.redir_rdy) begin
                    if (REFILL_CYCLES > 0) begin
                        state_d = ST_REFILL;
                        cnt_d   = 4'(REFILL_CYCLES);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REFILL: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset is synchronous, so outputs are gated by rst to read zero while it is held.
    always_comb begin
        bus.flush_o       = do_flush;
        bus.stall_o       = 1'b0;
        bus.redir_vld_o   = 1'b0;
        bus.redir_pc_o    = '0;
        bus.pc_misalign_o = 1'b0;
        if (!rst) begin
            bus.stall_o       = ~idle;
            bus.redir_vld_o   = (state_q == ST_REDIR);
            bus.redir_pc_o    = pc_q;
            bus.pc_misalign_o = misalign_q;
        end
    end

`ifdef BRU_PERF_CNT_EN
    redir_ctrl_perf_cnt u_bru_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .br_inc_i    (idle & bus.bru_output_vld & ~rst),
        .taken_inc_i (do_flush),
        .br_cnt_o    (br_cnt_o),
        .taken_cnt_o (taken_cnt_o)
    );
`endif
endmodule
